// File: rtl/trig_conditioner.sv
// Conditions one asynchronous trigger level: synchronise, width-qualify, veto/enable,
// then a single-cycle trig_out pulse followed by a fixed dead time. Rejections are counted.
module trig_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 2,
    parameter int DEADTIME    = 16,
    parameter int DT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig_in,
    input  logic        enable,
    input  logic        veto,
    input  logic        clear_cnt,
    output logic        trig_out,
    output logic        busy,
    output logic [15:0] n_glitch,
    output logic [15:0] n_vetoed
);

    localparam int WC_W = (MIN_WIDTH > 2) ? $clog2(MIN_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUALIFY  = 2'd1,
        DEAD     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    state_t                 state_q, state_d;
    logic [WC_W-1:0]        wcnt_q, wcnt_d;
    logic [DT_W-1:0]        dcnt_q, dcnt_d;
    logic                   trig_q, trig_d;
    logic                   busy_q, busy_d;
    logic [15:0]            n_glitch_q, n_glitch_d;
    logic [15:0]            n_vetoed_q, n_vetoed_d;

    logic s_w;
    logic rise_w;
    logic qualify_w;
    logic inc_glitch_w;
    logic inc_vetoed_w;

    assign s_w    = sync_q[SYNC_STAGES-1];
    assign rise_w = s_w & ~s_d_q;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        dcnt_d       = dcnt_q;
        trig_d       = 1'b0;
        qualify_w    = 1'b0;
        inc_glitch_w = 1'b0;
        inc_vetoed_w = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_w) begin
                    if (MIN_WIDTH == 1) begin
                        qualify_w = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                        wcnt_d  = WC_W'(1);
                    end
                end
            end
            QUALIFY: begin
                if (!s_w) begin
                    state_d      = IDLE;
                    inc_glitch_w = 1'b1;
                end else if (wcnt_q == WC_W'(MIN_WIDTH - 1)) begin
                    qualify_w = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            DEAD: begin
                if (dcnt_q == '0) begin
                    state_d = s_w ? WAIT_LOW : IDLE;
                end else begin
                    dcnt_d = dcnt_q - DT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (!s_w) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A qualified trigger either starts dead time or is counted as vetoed;
        // in both cases the level must drop before another trigger is considered.
        if (qualify_w) begin
            if (enable && !veto) begin
                trig_d  = 1'b1;
                state_d = DEAD;
                dcnt_d  = DT_W'(DEADTIME - 1);
            end else begin
                inc_vetoed_w = 1'b1;
                state_d      = WAIT_LOW;
            end
        end

        busy_d = (state_d == DEAD);
    end

    always_comb begin
        n_glitch_d = n_glitch_q;
        n_vetoed_d = n_vetoed_q;
        if (clear_cnt) begin
            n_glitch_d = '0;
            n_vetoed_d = '0;
        end else begin
            if (inc_glitch_w && (n_glitch_q != 16'hFFFF)) begin
                n_glitch_d = n_glitch_q + 16'd1;
            end
            if (inc_vetoed_w && (n_vetoed_q != 16'hFFFF)) begin
                n_vetoed_d = n_vetoed_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            s_d_q      <= 1'b0;
            state_q    <= IDLE;
            wcnt_q     <= '0;
            dcnt_q     <= '0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            n_glitch_q <= '0;
            n_vetoed_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], trig_in};
            s_d_q      <= s_w;
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            dcnt_q     <= dcnt_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            n_glitch_q <= n_glitch_d;
            n_vetoed_q <= n_vetoed_d;
        end
    end

    assign trig_out = trig_q;
    assign busy     = busy_q;
    assign n_glitch = n_glitch_q;
    assign n_vetoed = n_vetoed_q;

endmodule
